// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: combines ID, EX and MEM stall requests into
// a per-stage stall vector, tracks data-memory waits with a timeout FSM, kills
// wrong-path fetch on taken branches and counts PC-stall cycles.
module pipe_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_hazard_i,
  input  logic             ex_busy_i,
  input  logic             mem_req_i,
  input  logic             dmem_ack_i,
  input  logic             br_taken_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Last wait-counter value before the access is declared timed out.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_cnt_nxt;
  logic             w_mem_stall;
  logic [5:0]       w_stall;
  logic [CNT_W-1:0] r_stall_cnt;

  // Memory-wait FSM next state, wait counter update and MEM-level stall request.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_stall    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i && !dmem_ack_i) begin
          w_mem_stall    = 1'b1;
          w_state_nxt    = ST_WAIT;
          w_wait_cnt_nxt = 8'd1;
        end else begin
          w_wait_cnt_nxt = 8'd0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack_i) begin
          w_state_nxt    = ST_IDLE;
          w_wait_cnt_nxt = 8'd0;
        end else if (r_wait_cnt == WAIT_LAST) begin
          // Final stalled cycle of this access; the error cycle follows.
          w_mem_stall    = 1'b1;
          w_state_nxt    = ST_ERR;
          w_wait_cnt_nxt = 8'd0;
        end else begin
          w_mem_stall    = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      ST_ERR: begin
        // Any ack arriving here belongs to the abandoned access and is ignored.
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = 8'd0;
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Stall priority MEM > EX > ID; everything forced quiet while reset is high.
  always_comb begin
    w_stall = STALL_NONE;
    if (rst) begin
      w_stall = STALL_NONE;
    end else if (w_mem_stall) begin
      w_stall = STALL_MEM;
    end else if (ex_busy_i) begin
      w_stall = STALL_EX;
    end else if (ld_hazard_i) begin
      w_stall = STALL_ID;
    end else begin
      w_stall = STALL_NONE;
    end
  end

  assign stall_o     = w_stall;
  // A branch seen while ID is stalled is re-presented once ID advances.
  assign flush_o     = !rst && br_taken_i && !w_stall[2];
  assign bus_err_o   = !rst && (r_state == ST_ERR);
  assign stall_cnt_o = r_stall_cnt;

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall[0] && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each scenario drives one table row per cycle,
// pushes the expected outputs, then pops and compares mid-cycle. A second
// instance with a 4-bit counter exercises stall-counter saturation.
module tb_pipe_ctrl;

  localparam logic [5:0] I_RST = 6'b100000;
  localparam logic [5:0] I_LD  = 6'b010000;
  localparam logic [5:0] I_EX  = 6'b001000;
  localparam logic [5:0] I_MR  = 6'b000100;
  localparam logic [5:0] I_ACK = 6'b000010;
  localparam logic [5:0] I_BR  = 6'b000001;
  localparam logic [5:0] S_NO  = 6'b000000;
  localparam logic [5:0] S_ID  = 6'b000111;
  localparam logic [5:0] S_EX  = 6'b001111;
  localparam logic [5:0] S_MEM = 6'b011111;

  logic        clk = 1'b0;
  logic        rst, ld_hazard_i, ex_busy_i, mem_req_i, dmem_ack_i, br_taken_i;
  logic [5:0]  stall_o;
  logic        flush_o, bus_err_o;
  logic [31:0] stall_cnt_o;
  logic [5:0]  sat_stall;
  logic        sat_flush, sat_err;
  logic [3:0]  sat_cnt;

  logic [7:0]  exp_q[$];
  logic [31:0] cnt_q[$];
  logic [3:0]  cnts_q[$];
  logic [31:0] exp_cnt   = 32'd0;
  logic [3:0]  exp_cnt_s = 4'd0;
  int          n_checks  = 0;
  int          n_pass    = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(16), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .ld_hazard_i(ld_hazard_i), .ex_busy_i(ex_busy_i),
    .mem_req_i(mem_req_i), .dmem_ack_i(dmem_ack_i), .br_taken_i(br_taken_i),
    .stall_o(stall_o), .flush_o(flush_o), .bus_err_o(bus_err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  pipe_ctrl #(.TIMEOUT(16), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .ld_hazard_i(ld_hazard_i), .ex_busy_i(ex_busy_i),
    .mem_req_i(mem_req_i), .dmem_ack_i(dmem_ack_i), .br_taken_i(br_taken_i),
    .stall_o(sat_stall), .flush_o(sat_flush), .bus_err_o(sat_err),
    .stall_cnt_o(sat_cnt)
  );

  // Row layout: {inputs[5:0], bus_err, flush, stall[5:0]}
  function automatic logic [13:0] ent(input logic [5:0] in, input logic err,
                                      input logic fl, input logic [5:0] st);
    return {in, err, fl, st};
  endfunction

  // Apply one row's inputs and record its expected outputs and counts.
  task automatic drive(input logic [13:0] e);
    {rst, ld_hazard_i, ex_busy_i, mem_req_i, dmem_ack_i, br_taken_i} = e[13:8];
    exp_q.push_back(e[7:0]);
    cnt_q.push_back(exp_cnt);
    cnts_q.push_back(exp_cnt_s);
  endtask

  // Counter model advances from the expected stall, not from the DUT.
  task automatic advance(input logic [13:0] e);
    if (e[13]) begin
      exp_cnt   = 32'd0;
      exp_cnt_s = 4'd0;
    end else if (e[0]) begin
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      if (exp_cnt_s != 4'hF) exp_cnt_s = exp_cnt_s + 4'd1;
    end
  endtask

  task automatic test_reset();
    logic [13:0] tbl[$];
    logic [13:0] e;
    logic [7:0]  ev;
    logic [31:0] ec;
    logic [3:0]  ecs;
    tbl.push_back(ent(I_RST | I_LD | I_EX | I_MR | I_BR, 1'b0, 1'b0, S_NO));
    tbl.push_back(ent(I_MR | I_ACK, 1'b0, 1'b0, S_NO));
    tbl.push_back(ent(6'b000000, 1'b0, 1'b0, S_NO));
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      drive(e);
      @(negedge clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); ecs = cnts_q.pop_front();
      if ({bus_err_o, flush_o, stall_o} !== ev) $display("FAIL reset outs row %0d: got %b want %b", i, {bus_err_o, flush_o, stall_o}, ev);
      else n_pass++;
      n_checks++;
      if (stall_cnt_o !== ec) $display("FAIL reset cnt row %0d: got %0d want %0d", i, stall_cnt_o, ec);
      else n_pass++;
      n_checks++;
      advance(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_id_and_priority();
    logic [13:0] tbl[$];
    logic [13:0] e;
    logic [7:0]  ev;
    logic [31:0] ec;
    logic [3:0]  ecs;
    tbl.push_back(ent(I_LD, 1'b0, 1'b0, S_ID));
    tbl.push_back(ent(6'b000000, 1'b0, 1'b0, S_NO));
    tbl.push_back(ent(I_LD | I_EX | I_MR, 1'b0, 1'b0, S_MEM));
    tbl.push_back(ent(I_EX | I_MR | I_ACK, 1'b0, 1'b0, S_EX));
    tbl.push_back(ent(I_LD | I_MR | I_ACK, 1'b0, 1'b0, S_ID));
    tbl.push_back(ent(I_LD | I_EX, 1'b0, 1'b0, S_EX));
    tbl.push_back(ent(6'b000000, 1'b0, 1'b0, S_NO));
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      drive(e);
      @(negedge clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); ecs = cnts_q.pop_front();
      if ({bus_err_o, flush_o, stall_o} !== ev) $display("FAIL prio outs row %0d: got %b want %b", i, {bus_err_o, flush_o, stall_o}, ev);
      else n_pass++;
      n_checks++;
      if (stall_cnt_o !== ec) $display("FAIL prio cnt row %0d: got %0d want %0d", i, stall_cnt_o, ec);
      else n_pass++;
      n_checks++;
      advance(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_ack();
    logic [13:0] tbl[$];
    logic [13:0] e;
    logic [7:0]  ev;
    logic [31:0] ec;
    logic [3:0]  ecs;
    for (int k = 0; k < 3; k++) tbl.push_back(ent(I_MR, 1'b0, 1'b0, S_MEM));
    tbl.push_back(ent(I_MR | I_ACK, 1'b0, 1'b0, S_NO));
    tbl.push_back(ent(6'b000000, 1'b0, 1'b0, S_NO));
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      drive(e);
      @(negedge clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); ecs = cnts_q.pop_front();
      if ({bus_err_o, flush_o, stall_o} !== ev) $display("FAIL mem_ack outs row %0d: got %b want %b", i, {bus_err_o, flush_o, stall_o}, ev);
      else n_pass++;
      n_checks++;
      if (stall_cnt_o !== ec) $display("FAIL mem_ack cnt row %0d: got %0d want %0d", i, stall_cnt_o, ec);
      else n_pass++;
      n_checks++;
      advance(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    logic [13:0] tbl[$];
    logic [13:0] e;
    logic [7:0]  ev;
    logic [31:0] ec;
    logic [3:0]  ecs;
    tbl.push_back(ent(I_BR | I_LD, 1'b0, 1'b0, S_ID));
    tbl.push_back(ent(I_BR, 1'b0, 1'b1, S_NO));
    tbl.push_back(ent(I_BR | I_EX, 1'b0, 1'b0, S_EX));
    tbl.push_back(ent(I_BR | I_MR, 1'b0, 1'b0, S_MEM));
    tbl.push_back(ent(I_BR | I_ACK, 1'b0, 1'b1, S_NO));
    tbl.push_back(ent(6'b000000, 1'b0, 1'b0, S_NO));
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      drive(e);
      @(negedge clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); ecs = cnts_q.pop_front();
      if ({bus_err_o, flush_o, stall_o} !== ev) $display("FAIL flush outs row %0d: got %b want %b", i, {bus_err_o, flush_o, stall_o}, ev);
      else n_pass++;
      n_checks++;
      if (stall_cnt_o !== ec) $display("FAIL flush cnt row %0d: got %0d want %0d", i, stall_cnt_o, ec);
      else n_pass++;
      n_checks++;
      advance(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [13:0] tbl[$];
    logic [13:0] e;
    logic [7:0]  ev;
    logic [31:0] ec;
    logic [3:0]  ecs;
    for (int k = 0; k < 16; k++) tbl.push_back(ent(I_MR, 1'b0, 1'b0, S_MEM));
    tbl.push_back(ent(I_MR | I_ACK, 1'b1, 1'b0, S_NO));
    tbl.push_back(ent(I_MR, 1'b0, 1'b0, S_MEM));
    tbl.push_back(ent(I_MR | I_ACK, 1'b0, 1'b0, S_NO));
    tbl.push_back(ent(6'b000000, 1'b0, 1'b0, S_NO));
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      drive(e);
      @(negedge clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); ecs = cnts_q.pop_front();
      if ({bus_err_o, flush_o, stall_o} !== ev) $display("FAIL timeout outs row %0d: got %b want %b", i, {bus_err_o, flush_o, stall_o}, ev);
      else n_pass++;
      n_checks++;
      if (stall_cnt_o !== ec) $display("FAIL timeout cnt row %0d: got %0d want %0d", i, stall_cnt_o, ec);
      else n_pass++;
      n_checks++;
      if (sat_cnt !== ecs) $display("FAIL timeout sat_cnt row %0d: got %0d want %0d", i, sat_cnt, ecs);
      else n_pass++;
      n_checks++;
      advance(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [13:0] tbl[$];
    logic [13:0] e;
    logic [7:0]  ev;
    logic [31:0] ec;
    logic [3:0]  ecs;
    for (int k = 0; k < 5; k++) tbl.push_back(ent(I_MR, 1'b0, 1'b0, S_MEM));
    tbl.push_back(ent(I_RST | I_MR, 1'b0, 1'b0, S_NO));
    for (int k = 0; k < 16; k++) tbl.push_back(ent(I_MR, 1'b0, 1'b0, S_MEM));
    tbl.push_back(ent(6'b000000, 1'b1, 1'b0, S_NO));
    tbl.push_back(ent(6'b000000, 1'b0, 1'b0, S_NO));
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      drive(e);
      @(negedge clk);
      ev = exp_q.pop_front(); ec = cnt_q.pop_front(); ecs = cnts_q.pop_front();
      if ({bus_err_o, flush_o, stall_o} !== ev) $display("FAIL rst_wait outs row %0d: got %b want %b", i, {bus_err_o, flush_o, stall_o}, ev);
      else n_pass++;
      n_checks++;
      if (stall_cnt_o !== ec) $display("FAIL rst_wait cnt row %0d: got %0d want %0d", i, stall_cnt_o, ec);
      else n_pass++;
      n_checks++;
      if (sat_cnt !== ecs) $display("FAIL rst_wait sat_cnt row %0d: got %0d want %0d", i, sat_cnt, ecs);
      else n_pass++;
      n_checks++;
      advance(e);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    {rst, ld_hazard_i, ex_busy_i, mem_req_i, dmem_ack_i, br_taken_i} = I_RST;
    @(posedge clk); #1;
    test_reset();
    test_id_and_priority();
    test_mem_ack();
    test_flush();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
